down_timer: RTL and testbench

- Synchronous, loadable down-counter/timer. Complement to the team's ripple up-counter: same clk/reset scheme, counts in the opposite direction, and signals expiry.
- Software or an upstream FSM loads a terminal value and starts it. The counter then decrements on qualified ticks and emits a one-cycle done pulse at zero.
- Used for timeouts and delay generation beside the up-counter blocks.

---
 rtl/down_timer.sv | 124 ++++++++++++
 tb/tb_down_timer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Loadable down-counter/timer with a one-cycle done pulse at zero and a sticky expired state.
// Optional build macro DOWN_TIMER_AUTO_RELOAD_EN turns the terminal tick into a periodic reload.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             tick_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             expired_q, expired_d;
  logic             done_q, done_d;

  // State and registered outputs; reset aborts any countdown without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= CNT_ZERO;
      reload_q  <= CNT_ZERO;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic, priority load > stop > start > tick_en.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_IDLE;
      end else begin
        state_d = state_q;
      end
    end else if (start && (state_q != ST_RUN)) begin
      case (state_q)
        ST_IDLE: begin
          if (count_q != CNT_ZERO) begin
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
        ST_EXPIRED: begin
          count_d = reload_q;
          if (reload_q != CNT_ZERO) begin
            state_d = ST_RUN;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if ((state_q == ST_RUN) && tick_en) begin
      if (count_q == CNT_ONE) begin
        done_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        count_d = reload_q;
        state_d = ST_RUN;
`else
        count_d = CNT_ZERO;
        state_d = ST_EXPIRED;
`endif
      end else if (count_q != CNT_ZERO) begin
        count_d = count_q - CNT_ONE;
      end else begin
        // Unreachable in normal use; never wrap, fall back to IDLE.
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_EXPIRED) begin
      count_d = CNT_ZERO;
    end else begin
      state_d = state_q;
    end

    busy_d    = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  assign count   = count_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Table-driven directed bench for down_timer (WIDTH=4), plus hand-written multi-cycle sequences.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       stop;
  logic       tick_en;
  logic [3:0] count;
  logic       busy;
  logic       expired;
  logic       done;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  down_timer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .tick_en(tick_en),
    .count(count), .busy(busy), .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       st;
    logic       sp;
    logic       tk;
    logic [3:0] cnt;
    logic       bsy;
    logic       exp;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic ld, input logic [3:0] lv, input logic st,
                            input logic sp, input logic tk, input logic [3:0] cnt,
                            input logic bsy, input logic exp, input logic dn);
    vec_t e;
    e.ld = ld; e.lv = lv; e.st = st; e.sp = sp; e.tk = tk;
    e.cnt = cnt; e.bsy = bsy; e.exp = exp; e.dn = dn;
    vecs.push_back(e);
  endfunction

  task automatic check(input string name, input logic [3:0] cnt, input logic bsy,
                       input logic exp, input logic dn);
    tests_run++;
    if ({count, busy, expired, done} !== {cnt, bsy, exp, dn}) begin
      tests_failed++;
      $display("FAIL %s: got count=%0d busy=%0b expired=%0b done=%0b, want count=%0d busy=%0b expired=%0b done=%0b",
               name, count, busy, expired, done, cnt, bsy, exp, dn);
    end
  endtask

  task automatic drive(input logic ld, input logic [3:0] lv, input logic st,
                       input logic sp, input logic tk);
    load = ld; load_val = lv; start = st; stop = sp; tick_en = tk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    check("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();
    check("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    // Periodic strobe: 3,2,1,3,2,1 with done on each reload, expired never set.
    v(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
`else
    // Basic countdown from 5.
    v(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    // Gated ticks from 3.
    v(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    // Stop and restart from 9.
    v(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    // Restart from EXPIRED with reload 4.
    v(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    v(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    // Priority: load beats start; start with count 0 pulses done and stays IDLE.
    v(1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    v(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    v(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    v(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].tk);
      step();
      check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].bsy, vecs[i].exp, vecs[i].dn);
    end

    // Full range: load 15 takes exactly 15 ticks to done.
    drive(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    step();
    check("load15", 4'd15, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    check("start15", 4'd15, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      step();
      if (i < 15)
        check($sformatf("tick15_%0d", i), 4'(15 - i), 1'b1, 1'b0, 1'b0);
      else if (AUTO)
        check("tick15_last", 4'd15, 1'b1, 1'b0, 1'b1);
      else
        check("tick15_last", 4'd0, 1'b0, 1'b1, 1'b1);
    end

    // Async reset mid-RUN at count 6, applied between clock edges.
    drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    step();
    check("pre_reset_run", 4'd6, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    step();
    check("post_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("post_reset_hold", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
